braille_cell_presenter: RTL and testbench
=========================================

Name: braille_cell_presenter

Overview:
- Downstream consumer of the 100 ms LFSR timebase's `timeout_100ms` pulse.
- Accepts one 6-dot braille cell pattern from the trainer controller over a valid/ready handshake.
- Drives the cell onto the dot actuators for a fixed number of 100 ms ticks, blanks them for an inter-character gap, then reports completion.
- Sits between the character sequencer (upstream) and the dot driver outputs (downstream).

Parameters:
- HOLD_TICKS, default 10: number of 100 ms ticks the pattern is shown (1.0 s). Legal range 1..31.
- GAP_TICKS, default 3: number of 100 ms ticks of blank gap after the hold (0.3 s). Legal range 0..31; 0 skips the gap.
- CNT_W, default 5: tick counter width. Must hold max(HOLD_TICKS, GAP_TICKS).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- tick_100ms  in  1  one-clk pulse from the 100 ms LFSR counter's `timeout_100ms`.
- abort  in  1  synchronous cancel from the trainer controller.
- char_valid  in  1  upstream has a pattern.
- char_pattern  in  6  dot pattern; bit0 = dot1 … bit5 = dot6.
- char_ready  out  1  block can accept a pattern.
- dots  out  6  actuator drive, registered.
- dots_on  out  1  high while the pattern is displayed.
- busy  out  1  high in HOLD or GAP.
- done  out  1  one-clk pulse when a cell completes normally.

Behaviour:
- Reset values (asynchronous, while rst=1):
  - state = IDLE, counter = 0.
  - dots = 6'b000000, dots_on = 0, busy = 0, done = 0, char_ready = 1.
- State machine: IDLE, HOLD, GAP.
- IDLE:
  - char_ready = 1.
  - Accept occurs when char_valid & char_ready at a rising edge. On accept: latch char_pattern into dots, set dots_on=1, busy=1, counter=0, next state = HOLD.
  - Latency: dots are valid on the clk edge of acceptance (registered, 1 cycle after the inputs are sampled).
- HOLD:
  - char_ready = 0; char_valid is ignored and the pattern is not re-sampled.
  - Each tick_100ms increments the counter.
  - A tick that occurs in the same cycle as the accept is not counted. Counting starts the cycle after the accept.
  - When the HOLD_TICKS-th tick arrives: dots = 0, dots_on = 0, counter = 0.
    - If GAP_TICKS > 0, next state = GAP.
    - If GAP_TICKS = 0, next state = IDLE, done = 1 for one cycle, busy = 0.
  - Resulting hold duration is between HOLD_TICKS-1 and HOLD_TICKS tick periods (no tick alignment is performed).
- GAP:
  - dots = 0; ticks are counted the same way as in HOLD.
  - On the GAP_TICKS-th tick: next state = IDLE, done = 1 for one cycle, busy = 0.
  - char_ready rises on the cycle after done, i.e. it is 1 in IDLE.
  - Back-to-back cells are therefore separated by at least one idle clk.
- abort:
  - Has priority over tick and over accept.
  - In any state, at the next edge: state = IDLE, dots = 0, dots_on = 0, busy = 0, counter = 0, done = 0.
  - A cell that is aborted never produces done.
  - In IDLE, abort with char_valid=1 blocks the accept in that cycle.
- rst asserted mid-HOLD or mid-GAP: outputs immediately take their reset values and no done is emitted.
- Counter never wraps. It is cleared on every state entry and compared for equality against the parameter value.
- tick_100ms in IDLE is ignored.

Decomposition:
- Package braille_presenter_pkg:
  - state encoding constants S_IDLE = 2'd0, S_HOLD = 2'd1, S_GAP = 2'd2 (2'd3 is illegal and recovers to IDLE).
  - DOTS_BLANK = 6'b000000.
  - DOT_W = 6.
- One natural sub-module, braille_tick_counter:
  - Inputs: clk, rst, clear, tick. Parameterised terminal value.
  - Output: `hit` pulse on the terminal tick.
  - Instantiated once; its terminal value is muxed between HOLD_TICKS and GAP_TICKS by state.

Test Plan:
- Bench tick = 1 pulse every 5 clk, HOLD_TICKS=10, GAP_TICKS=3.
  - After reset release, assert char_valid with char_pattern=6'b101011 -> dots=6'b101011 and dots_on=1 one edge later; char_ready=0.
  - On the 10th tick: dots=0. On the 13th tick: done pulses for exactly 1 clk, then char_ready=1.
- Tick coincident with the accept cycle -> that tick is not counted; dots clear on the 11th tick pulse seen on the bus (the 10th counted).
- GAP_TICKS=0 -> done pulses in the same cycle dots clear on the 10th tick; the state never enters GAP.
- abort on the 4th tick edge during HOLD with pattern 6'b111111 -> dots=0 next edge; busy=0; no done for 20 ticks afterwards.
- char_valid held high with pattern 6'b000111 during HOLD of pattern 6'b110000 -> dots stays 6'b110000.
  - After done, 6'b000111 is accepted exactly one clk after char_ready rises.
- rst pulse mid-GAP -> all outputs at reset values while rst=1, asynchronously without waiting for a clk edge.
  - The next accepted cell completes normally with full HOLD and GAP counts.

Source files
------------

// File: rtl/braille_cell_presenter_pkg.sv
// Shared definitions for the braille cell presenter.
// Contents:
//   DOT_W      - number of dots in one braille cell (6).
//   DOTS_BLANK - all-actuators-off pattern.
//   state_e    - presenter FSM encoding. 2'd3 is not a legal state; the FSM
//                treats it as a fault and returns to IDLE.
package braille_presenter_pkg;

    localparam int DOT_W = 6;

    localparam logic [DOT_W-1:0] DOTS_BLANK = 6'b000000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_GAP  = 2'd2
    } state_e;

endpackage

// File: rtl/braille_cell_presenter_if.sv
// Character handshake between the character sequencer and the presenter.
// Signals:
//   char_valid   - sequencer has a cell pattern to show.
//   char_pattern - dot pattern, bit0 = dot1 ... bit5 = dot6.
//   char_ready   - presenter can accept a pattern this cycle.
// Modports:
//   master - sequencer side (drives valid/pattern).
//   slave  - presenter side (drives ready).
interface braille_cell_presenter_if;
    import braille_presenter_pkg::*;

    logic             char_valid;
    logic [DOT_W-1:0] char_pattern;
    logic             char_ready;

    modport master (
        output char_valid,
        output char_pattern,
        input  char_ready
    );

    modport slave (
        input  char_valid,
        input  char_pattern,
        output char_ready
    );
endinterface

// File: rtl/braille_cell_presenter_tick_counter.sv
// braille_tick_counter: counts 100 ms ticks up to a terminal value.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset.
//   clear     - forces the count to zero and suppresses hit.
//   tick      - one-clk tick pulse to be counted.
//   terminal  - number of ticks after which hit fires (must be >= 1).
//   hit       - combinational pulse in the cycle of the terminal tick.
// The count restarts from zero after a hit, so it never wraps.
module braille_tick_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             tick,
    input  logic [CNT_W-1:0] terminal,
    output logic             hit
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W:0]   count_inc;

    // One extra bit so the comparison cannot alias when terminal is at its maximum.
    assign count_inc = {1'b0, count_q} + {{CNT_W{1'b0}}, 1'b1};
    assign hit       = tick & ~clear & (count_inc == {1'b0, terminal});

    always_comb begin
        count_d = count_q;
        if (clear || hit) begin
            count_d = '0;
        end else if (tick) begin
            count_d = count_inc[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/braille_cell_presenter.sv
// braille_cell_presenter: shows one 6-dot braille cell on the actuators for
// HOLD_TICKS 100 ms ticks, blanks for GAP_TICKS ticks, then pulses done.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset.
//   tick_100ms  - one-clk pulse from the 100 ms timebase.
//   abort       - synchronous cancel; beats both tick and accept.
//   bus         - character handshake (slave side).
//   dots        - registered actuator drive.
//   dots_on     - high while the pattern is displayed.
//   busy        - high in HOLD or GAP.
//   done        - one-clk pulse when a cell completes without abort.
module braille_cell_presenter
    import braille_presenter_pkg::*;
#(
    parameter int HOLD_TICKS = 10,
    parameter int GAP_TICKS  = 3,
    parameter int CNT_W      = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick_100ms,
    input  logic                     abort,
    braille_cell_presenter_if.slave  bus,
    output logic [DOT_W-1:0]         dots,
    output logic                     dots_on,
    output logic                     busy,
    output logic                     done
);

    localparam bit HAS_GAP = (GAP_TICKS > 0);

    state_e           state_q, state_d;
    logic [DOT_W-1:0] dots_q, dots_d;
    logic             dots_on_q, dots_on_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             char_ready;
    logic             accept;
    logic             cnt_clear;
    logic             cnt_hit;
    logic [CNT_W-1:0] cnt_terminal;

    // Ready is held low during the done cycle so consecutive cells are
    // always separated by at least one idle clock.
    assign char_ready     = (state_q == S_IDLE) && !done_q;
    assign bus.char_ready = char_ready;
    assign accept         = bus.char_valid && char_ready && !abort;

    // Counter is held clear outside HOLD/GAP, so a tick coincident with the
    // accept edge is never counted; HOLD->GAP restarts via the counter's own
    // clear-on-hit.
    assign cnt_clear    = abort || ((state_q != S_HOLD) && (state_q != S_GAP));
    assign cnt_terminal = (state_q == S_GAP) ? CNT_W'(GAP_TICKS) : CNT_W'(HOLD_TICKS);

    braille_tick_counter #(
        .CNT_W (CNT_W)
    ) u_tick_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .tick     (tick_100ms),
        .terminal (cnt_terminal),
        .hit      (cnt_hit)
    );

    always_comb begin
        state_d   = state_q;
        dots_d    = dots_q;
        dots_on_d = dots_on_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (abort) begin
            state_d   = S_IDLE;
            dots_d    = DOTS_BLANK;
            dots_on_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_d   = S_HOLD;
                        dots_d    = bus.char_pattern;
                        dots_on_d = 1'b1;
                        busy_d    = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt_hit) begin
                        dots_d    = DOTS_BLANK;
                        dots_on_d = 1'b0;
                        if (HAS_GAP) begin
                            state_d = S_GAP;
                        end else begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    dots_d = DOTS_BLANK;
                    if (cnt_hit) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d   = S_IDLE;
                    dots_d    = DOTS_BLANK;
                    dots_on_d = 1'b0;
                    busy_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            dots_q    <= DOTS_BLANK;
            dots_on_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dots_q    <= dots_d;
            dots_on_q <= dots_on_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign dots    = dots_q;
    assign dots_on = dots_on_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_braille_cell_presenter.sv
module tb_braille_cell_presenter;
    import braille_presenter_pkg::*;

    localparam int HOLD = 10;
    localparam int GAP  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       abort_m, abort_z;
    logic [5:0] dots_m, dots_z;
    logic       on_m, on_z, busy_m, busy_z, done_m, done_z;
    int         phase;

    int n_cmp = 0;
    int n_bad = 0;
    logic [5:0] exp_q[$];

    braille_cell_presenter_if bus_m ();
    braille_cell_presenter_if bus_z ();

    braille_cell_presenter #(.HOLD_TICKS(HOLD), .GAP_TICKS(GAP), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .tick_100ms(tick), .abort(abort_m), .bus(bus_m),
        .dots(dots_m), .dots_on(on_m), .busy(busy_m), .done(done_m));

    braille_cell_presenter #(.HOLD_TICKS(HOLD), .GAP_TICKS(0), .CNT_W(5)) dut_z (
        .clk(clk), .rst(rst), .tick_100ms(tick), .abort(abort_z), .bus(bus_z),
        .dots(dots_z), .dots_on(on_z), .busy(busy_z), .done(done_z));

    always #5 clk = ~clk;

    // Tick: one pulse every 5 clk, updated 1 ns after the edge.
    initial begin
        tick  = 1'b0;
        phase = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                phase = 0;
                tick  = 1'b0;
            end else begin
                phase = (phase == 4) ? 0 : phase + 1;
                tick  = (phase == 4);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic align_tick(input logic want);
        int guard = 0;
        while (tick !== want && guard < 10) begin
            step();
            guard++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        n_cmp++;
        if (dots_m !== 6'd0 || on_m !== 1'b0 || busy_m !== 1'b0 || done_m !== 1'b0 || bus_m.char_ready !== 1'b1) begin
            $display("FAIL reset_main: dots=%b on=%b busy=%b done=%b rdy=%b want 000000 0 0 0 1",
                     dots_m, on_m, busy_m, done_m, bus_m.char_ready);
            n_bad++;
        end
        n_cmp++;
        if (dots_z !== 6'd0 || on_z !== 1'b0 || busy_z !== 1'b0 || done_z !== 1'b0 || bus_z.char_ready !== 1'b1) begin
            $display("FAIL reset_gap0: dots=%b on=%b busy=%b done=%b rdy=%b want 000000 0 0 0 1",
                     dots_z, on_z, busy_z, done_z, bus_z.char_ready);
            n_bad++;
        end
        rst = 1'b0;
        step();
        step();
        $display("reset released: dots=%b rdy=%b", dots_m, bus_m.char_ready);
    endtask

    // Present one cell on the main instance and check the full hold/gap/done
    // timeline. align=1 places a tick in the accept cycle (must not count).
    task automatic present_cell(input logic [5:0] pat, input logic align,
                                input logic [5:0] next_pat, input logic next_valid);
        int         ticks, hold_end, done_end;
        logic [5:0] exp_pat;
        logic       exp_on;
        bit         finished;
        align_tick(align);
        n_cmp++;
        if (bus_m.char_ready !== 1'b1) begin
            $display("FAIL cell_ready_idle: rdy=%b want 1", bus_m.char_ready);
            n_bad++;
        end
        bus_m.char_valid   = 1'b1;
        bus_m.char_pattern = pat;
        exp_q.push_back(pat);
        ticks    = align ? 1 : 0;
        hold_end = ticks + HOLD;
        done_end = hold_end + GAP;
        step();
        bus_m.char_valid   = next_valid;
        bus_m.char_pattern = next_pat;
        exp_pat = exp_q.pop_front();
        n_cmp++;
        if (dots_m !== exp_pat || on_m !== 1'b1 || bus_m.char_ready !== 1'b0 || busy_m !== 1'b1) begin
            $display("FAIL cell_accept: dots=%b on=%b rdy=%b busy=%b want %b 1 0 1",
                     dots_m, on_m, bus_m.char_ready, busy_m, exp_pat);
            n_bad++;
        end
        finished = 1'b0;
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            if (tick === 1'b1) ticks++;
            step();
            exp_on = (ticks < hold_end);
            n_cmp++;
            if (on_m !== exp_on || dots_m !== (exp_on ? exp_pat : 6'b000000)) begin
                $display("FAIL cell_dots: tick %0d dots=%b on=%b want on=%b pat=%b",
                         ticks, dots_m, on_m, exp_on, exp_pat);
                n_bad++;
            end
            if (ticks == done_end) begin
                n_cmp++;
                if (done_m !== 1'b1 || busy_m !== 1'b0 || bus_m.char_ready !== 1'b0) begin
                    $display("FAIL cell_done: done=%b busy=%b rdy=%b want 1 0 0", done_m, busy_m, bus_m.char_ready);
                    n_bad++;
                end
                step();
                n_cmp++;
                if (done_m !== 1'b0 || bus_m.char_ready !== 1'b1) begin
                    $display("FAIL cell_ready_after: done=%b rdy=%b want 0 1", done_m, bus_m.char_ready);
                    n_bad++;
                end
                finished = 1'b1;
            end else begin
                n_cmp++;
                if (done_m !== 1'b0 || busy_m !== 1'b1) begin
                    $display("FAIL cell_early_done: tick %0d done=%b busy=%b want 0 1", ticks, done_m, busy_m);
                    n_bad++;
                end
            end
        end
        n_cmp++;
        if (!finished) begin
            $display("FAIL cell_timeout: ticks=%0d want %0d", ticks, done_end);
            n_bad++;
        end
        $display("cell %b align=%0d: %0d bus ticks to done", pat, align, ticks);
    endtask

    task automatic test_basic();
        present_cell(6'b101011, 1'b0, 6'b000000, 1'b0);
    endtask

    task automatic test_coincident_tick();
        present_cell(6'b011001, 1'b1, 6'b000000, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_pat;
        present_cell(6'b110000, 1'b0, 6'b000111, 1'b1);
        exp_q.push_back(6'b000111);
        step();
        bus_m.char_valid = 1'b0;
        exp_pat = exp_q.pop_front();
        n_cmp++;
        if (dots_m !== exp_pat || on_m !== 1'b1) begin
            $display("FAIL b2b_second_accept: dots=%b on=%b want %b 1", dots_m, on_m, exp_pat);
            n_bad++;
        end
        abort_m = 1'b1;
        step();
        abort_m = 1'b0;
        $display("back-to-back second cell: dots=%b", exp_pat);
    endtask

    task automatic test_abort();
        int         ticks = 0;
        bit         saw_done = 1'b0;
        logic [5:0] exp_pat;
        align_tick(1'b0);
        bus_m.char_valid   = 1'b1;
        bus_m.char_pattern = 6'b111111;
        exp_q.push_back(6'b111111);
        step();
        bus_m.char_valid = 1'b0;
        exp_pat = exp_q.pop_front();
        n_cmp++;
        if (dots_m !== exp_pat) begin
            $display("FAIL abort_accept: dots=%b want %b", dots_m, exp_pat);
            n_bad++;
        end
        for (int cyc = 0; cyc < 40 && ticks < 4; cyc++) begin
            if (tick === 1'b1) begin
                ticks++;
                if (ticks == 4) abort_m = 1'b1;
            end
            step();
        end
        abort_m = 1'b0;
        n_cmp++;
        if (ticks != 4 || dots_m !== 6'd0 || on_m !== 1'b0 || busy_m !== 1'b0 || done_m !== 1'b0) begin
            $display("FAIL abort_hold: ticks=%0d dots=%b on=%b busy=%b done=%b want 4 000000 0 0 0",
                     ticks, dots_m, on_m, busy_m, done_m);
            n_bad++;
        end
        for (int cyc = 0; cyc < 105; cyc++) begin
            step();
            if (done_m !== 1'b0 || on_m !== 1'b0) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done) begin
            $display("FAIL abort_no_done: saw done/dots_on after abort, want none for 20 ticks");
            n_bad++;
        end
        bus_m.char_valid   = 1'b1;
        bus_m.char_pattern = 6'b100001;
        abort_m = 1'b1;
        step();
        bus_m.char_valid = 1'b0;
        abort_m = 1'b0;
        n_cmp++;
        if (on_m !== 1'b0 || busy_m !== 1'b0 || dots_m !== 6'd0) begin
            $display("FAIL abort_idle_blocks: on=%b busy=%b dots=%b want 0 0 000000", on_m, busy_m, dots_m);
            n_bad++;
        end
        $display("abort after tick %0d: dots=%b busy=%b", ticks, dots_m, busy_m);
    endtask

    task automatic test_gap_zero();
        int  ticks = 0;
        bit  finished = 1'b0;
        align_tick(1'b0);
        bus_z.char_valid   = 1'b1;
        bus_z.char_pattern = 6'b010110;
        step();
        bus_z.char_valid = 1'b0;
        for (int cyc = 0; cyc < 100 && !finished; cyc++) begin
            if (tick === 1'b1) ticks++;
            step();
            if (ticks == HOLD) begin
                n_cmp++;
                if (done_z !== 1'b1 || dots_z !== 6'd0 || on_z !== 1'b0 || busy_z !== 1'b0) begin
                    $display("FAIL gap0_done: done=%b dots=%b on=%b busy=%b want 1 000000 0 0",
                             done_z, dots_z, on_z, busy_z);
                    n_bad++;
                end
                step();
                n_cmp++;
                if (done_z !== 1'b0 || busy_z !== 1'b0 || bus_z.char_ready !== 1'b1) begin
                    $display("FAIL gap0_after: done=%b busy=%b rdy=%b want 0 0 1", done_z, busy_z, bus_z.char_ready);
                    n_bad++;
                end
                finished = 1'b1;
            end else if (done_z !== 1'b0 || dots_z !== 6'b010110) begin
                n_cmp++;
                $display("FAIL gap0_hold: tick %0d done=%b dots=%b want 0 010110", ticks, done_z, dots_z);
                n_bad++;
            end
        end
        n_cmp++;
        if (!finished) begin
            $display("FAIL gap0_timeout: ticks=%0d want %0d", ticks, HOLD);
            n_bad++;
        end
        $display("gap0 cell done after %0d ticks", ticks);
    endtask

    task automatic test_reset_mid_gap();
        int         ticks = 0;
        bit         saw_done = 1'b0;
        logic [5:0] exp_pat;
        align_tick(1'b0);
        bus_m.char_valid   = 1'b1;
        bus_m.char_pattern = 6'b101010;
        exp_q.push_back(6'b101010);
        step();
        bus_m.char_valid = 1'b0;
        exp_pat = exp_q.pop_front();
        n_cmp++;
        if (dots_m !== exp_pat) begin
            $display("FAIL rstgap_accept: dots=%b want %b", dots_m, exp_pat);
            n_bad++;
        end
        for (int cyc = 0; cyc < 100 && ticks < HOLD + 1; cyc++) begin
            if (tick === 1'b1) ticks++;
            step();
            if (done_m !== 1'b0) saw_done = 1'b1;
        end
        n_cmp++;
        if (ticks != HOLD + 1 || busy_m !== 1'b1 || on_m !== 1'b0) begin
            $display("FAIL rstgap_in_gap: ticks=%0d busy=%b on=%b want %0d 1 0", ticks, busy_m, on_m, HOLD + 1);
            n_bad++;
        end
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (dots_m !== 6'd0 || on_m !== 1'b0 || busy_m !== 1'b0 || done_m !== 1'b0 || bus_m.char_ready !== 1'b1) begin
            $display("FAIL rstgap_async: dots=%b on=%b busy=%b done=%b rdy=%b want 000000 0 0 0 1",
                     dots_m, on_m, busy_m, done_m, bus_m.char_ready);
            n_bad++;
        end
        step();
        rst = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            step();
            if (done_m !== 1'b0 || busy_m !== 1'b0) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done) begin
            $display("FAIL rstgap_no_done: done or busy seen around reset, want none");
            n_bad++;
        end
        $display("reset mid-gap at tick %0d", ticks);
        present_cell(6'b010101, 1'b0, 6'b000000, 1'b0);
    endtask

    initial begin
        rst                = 1'b1;
        abort_m            = 1'b0;
        abort_z            = 1'b0;
        bus_m.char_valid   = 1'b0;
        bus_m.char_pattern = 6'd0;
        bus_z.char_valid   = 1'b0;
        bus_z.char_pattern = 6'd0;
        test_reset();
        test_basic();
        test_coincident_tick();
        test_gap_zero();
        test_abort();
        test_back_to_back();
        test_reset_mid_gap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
